// File: rtl/bomb_ctrl_pkg.sv
// Shared constants for the bomb controller input path and password FSM.
// Button indices, button count and the default debounce length.
package bomb_ctrl_pkg;

  localparam int BTN_COUNT = 3;
  localparam int BTN0 = 0;
  localparam int BTN1 = 1;
  localparam int BTN2 = 2;

  localparam int DEBOUNCE_CYCLES_DEF = 16;

  typedef logic [BTN_COUNT-1:0] btn_vec_t;

endpackage

// File: rtl/button_conditioner_if.sv
// Board-side bundle of the button conditioner: raw pins in,
// clean press pulses and mode level out.
interface button_conditioner_if;

  logic btn0_raw;
  logic btn1_raw;
  logic btn2_raw;
  logic mode_raw;
  logic btn0;
  logic btn1;
  logic btn2;
  logic mode;

  modport master (
    output btn0_raw, btn1_raw, btn2_raw, mode_raw,
    input  btn0, btn1, btn2, mode
  );

  modport slave (
    input  btn0_raw, btn1_raw, btn2_raw, mode_raw,
    output btn0, btn1, btn2, mode
  );

endinterface

// File: rtl/debounce_cell.sv
// One input channel: 2-FF synchroniser, debounce counter,
// stable level and registered rising-edge pulse.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic sync_nreset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stable_q, stable_d;
  logic             prev_q, prev_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d     = raw_i;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    prev_d = stable_q;
    rise_d = stable_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!sync_nreset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  // prev_q is used as the level so it lines up with the rise pulse
  assign level_o = prev_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/button_conditioner.sv
// Button/mode front end: debounce cells, press priority mux and,
// with BTN_AUTOREPEAT_EN defined, per-button hold auto-repeat.
module button_conditioner
  import bomb_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 32
) (
  input  logic clk,
  input  logic sync_nreset,
  input  logic btn0_raw,
  input  logic btn1_raw,
  input  logic btn2_raw,
  input  logic mode_raw,
  output logic btn0,
  output logic btn1,
  output logic btn2,
  output logic mode
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 ||
      REPEAT_PERIOD < 1 ||
      REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("button_conditioner: bad parameters");
  end

  btn_vec_t raw_w;
  btn_vec_t level;
  btn_vec_t rise;
  btn_vec_t rep;
  btn_vec_t req;
  btn_vec_t pulse;
  logic     mode_rise_unused;

  assign raw_w = {btn2_raw, btn1_raw, btn0_raw};

  for (genvar i = 0; i < BTN_COUNT; i++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk        (clk),
      .sync_nreset(sync_nreset),
      .raw_i      (raw_w[i]),
      .level_o    (level[i]),
      .rise_o     (rise[i])
    );
  end

  debounce_cell #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode (
    .clk        (clk),
    .sync_nreset(sync_nreset),
    .raw_i      (mode_raw),
    .level_o    (mode),
    .rise_o     (mode_rise_unused)
  );

`ifdef BTN_AUTOREPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [HOLD_W-1:0] HOLD_FIRE =
    HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD =
    HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [HOLD_W-1:0] hold_q [BTN_COUNT];
  logic [HOLD_W-1:0] hold_d [BTN_COUNT];
  btn_vec_t          rep_q, rep_d;

  // level rises with the press pulse, so a high level means counting
  always_comb begin
    for (int i = 0; i < BTN_COUNT; i++) begin
      hold_d[i] = '0;
      rep_d[i]  = 1'b0;
      if (level[i]) begin
        if (rise[i]) begin
          hold_d[i] = HOLD_W'(1);
        end else if (hold_q[i] == HOLD_FIRE) begin
          hold_d[i] = HOLD_RELOAD;
          rep_d[i]  = 1'b1;
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_nreset) begin
      for (int i = 0; i < BTN_COUNT; i++) begin
        hold_q[i] <= '0;
      end
      rep_q <= '0;
    end else begin
      for (int i = 0; i < BTN_COUNT; i++) begin
        hold_q[i] <= hold_d[i];
      end
      rep_q <= rep_d;
    end
  end

  assign rep = rep_q;
`else
  logic level_unused;

  assign level_unused = ^level;
  assign rep          = '0;
`endif

  assign req = rise | rep;

  // losers of a simultaneous request are dropped, not queued
  always_comb begin
    pulse = '0;
    unique case (1'b1)
      req[BTN0]: pulse[BTN0] = 1'b1;
      req[BTN1] & ~req[BTN0]: pulse[BTN1] = 1'b1;
      req[BTN2] & ~req[BTN1] & ~req[BTN0]:
        pulse[BTN2] = 1'b1;
      default: ;
    endcase
  end

  assign btn0 = pulse[BTN0];
  assign btn1 = pulse[BTN1];
  assign btn2 = pulse[BTN2];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=4).
module tb_button_conditioner;

  localparam int DC = 4;
  localparam int RD = 8;
  localparam int RP = 4;
  localparam int BIG = 1 << 30;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic sync_nreset;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .sync_nreset(sync_nreset),
    .btn0_raw   (bus.btn0_raw),
    .btn1_raw   (bus.btn1_raw),
    .btn2_raw   (bus.btn2_raw),
    .mode_raw   (bus.mode_raw),
    .btn0       (bus.btn0),
    .btn1       (bus.btn1),
    .btn2       (bus.btn2),
    .mode       (bus.mode)
  );

  always #5 clk = ~clk;

  int t      = 0;
  int passed = 0;
  int total  = 0;
  int p_at   = -100;
  int r_end  = -100;
  int m_on   = BIG;
  int m_off  = BIG;
  logic [2:0] p_vec = 3'b000;

  // press pulse at p_at; repeats (if built in) until r_end
  function automatic logic [2:0] exp_btn(input int tt);
    if (tt == p_at) return p_vec;
    if (AR && tt >= p_at + RD && tt <= r_end &&
        (tt - p_at - RD) % RP == 0) return p_vec;
    return 3'b000;
  endfunction

  task automatic tick(input int n);
    logic [2:0] ob;
    logic [2:0] eb;
    logic       om;
    logic       em;
    repeat (n) begin
      @(posedge clk);
      t++;
      #2;
      ob = {bus.btn2, bus.btn1, bus.btn0};
      eb = exp_btn(t);
      total++;
      assert (ob === eb) passed++;
      else $error("FAIL btn t=%0d observed=%b expected=%b",
                  t, ob, eb);
      om = bus.mode;
      em = (t >= m_on && t < m_off);
      total++;
      assert (om === em) passed++;
      else $error("FAIL mode t=%0d observed=%b expected=%b",
                  t, om, em);
    end
  endtask

  initial begin
    sync_nreset  = 1'b0;
    bus.btn0_raw = 1'b0;
    bus.btn1_raw = 1'b0;
    bus.btn2_raw = 1'b0;
    bus.mode_raw = 1'b0;

    // 1: reset then idle
    tick(3);
    sync_nreset = 1'b1;
    tick(20);

    // 2: clean btn1 press, long hold, release
    bus.btn1_raw = 1'b1;
    p_vec = 3'b010;
    p_at  = t + DC + 3;
    r_end = BIG;
    tick(20);
    bus.btn1_raw = 1'b0;
    r_end = t + DC + 3;
    tick(12);

    // 3: btn0 bounce then settle
    bus.btn0_raw = 1'b1; tick(1);
    bus.btn0_raw = 1'b0; tick(1);
    bus.btn0_raw = 1'b1; tick(1);
    bus.btn0_raw = 1'b0; tick(1);
    bus.btn0_raw = 1'b1;
    p_vec = 3'b001;
    p_at  = t + DC + 3;
    r_end = BIG;
    tick(10);
    bus.btn0_raw = 1'b0;
    r_end = t + DC + 3;
    tick(12);

    // 4: btn0 and btn2 together, btn0 wins
    bus.btn0_raw = 1'b1;
    bus.btn2_raw = 1'b1;
    p_vec = 3'b001;
    p_at  = t + DC + 3;
    r_end = BIG;
    tick(10);
    bus.btn0_raw = 1'b0;
    bus.btn2_raw = 1'b0;
    r_end = t + DC + 3;
    tick(12);

    // 5: mode glitch, then real switch and back
    bus.mode_raw = 1'b1; tick(3);
    bus.mode_raw = 1'b0; tick(8);
    bus.mode_raw = 1'b1;
    m_on  = t + DC + 3;
    m_off = BIG;
    tick(12);
    bus.mode_raw = 1'b0;
    m_off = t + DC + 3;
    tick(10);

    // 6: reset in the middle of a btn2 debounce
    bus.btn2_raw = 1'b1;
    tick(2);
    sync_nreset = 1'b0;
    tick(2);
    sync_nreset = 1'b1;
    p_vec = 3'b100;
    p_at  = t + DC + 3;
    r_end = BIG;
    tick(25);
    bus.btn2_raw = 1'b0;
    r_end = t + DC + 3;
    tick(12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
